// File: rtl/matmul_io_pkg.sv
// Shared types, address-map constants and helpers for the matmul operand I/O path.
// The address map macros may be overridden on the command line.
`ifndef INPUT_MAT_BASE_ADDR
`define INPUT_MAT_BASE_ADDR 32'h0000_1000
`endif
`ifndef MEM_ADDR_INCR
`define MEM_ADDR_INCR 32'h0000_0010
`endif
`ifndef MEM_PORT_WIDTH
`define MEM_PORT_WIDTH 128
`endif

package matmul_io_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMemRd,
    StMemRdDelay,
    StStream,
    StDone
  } loader_state_e;

  localparam logic [31:0] InputMatBaseAddr = `INPUT_MAT_BASE_ADDR;
  localparam logic [31:0] MemAddrIncr      = `MEM_ADDR_INCR;
  localparam int unsigned MemPortWidth     = `MEM_PORT_WIDTH;

  // Number of skewed beats needed to drain a rows x cols operand through the lanes.
  function automatic int unsigned stream_beats(input int unsigned rows, input int unsigned cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/matmul_input_skew.sv
// Combinational lane selector: for beat t, lane c carries buf[t-c][c] when that row exists.
module matmul_input_skew #(
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 4,
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned BEAT_W    = 3
) (
  input  logic [ROWS*COLS*WORD_SIZE-1:0] buf_flat,
  input  logic [BEAT_W-1:0]              beat,
  output logic [COLS*WORD_SIZE-1:0]      lane_data,
  output logic [COLS-1:0]                lane_valid
);

  always_comb begin
    lane_data  = '0;
    lane_valid = '0;
    for (int c = 0; c < int'(COLS); c++) begin
      if ((int'(beat) >= c) && ((int'(beat) - c) < int'(ROWS))) begin
        lane_valid[c] = 1'b1;
        lane_data[c*WORD_SIZE +: WORD_SIZE] =
            buf_flat[((int'(beat) - c) * int'(COLS) + c) * int'(WORD_SIZE) +: WORD_SIZE];
      end
    end
  end

endmodule

// File: rtl/matmul_input_loader.sv
// Reads ROWS memory rows into a buffer, then streams them as skewed lanes, each beat held 2 cycles.
// Define LOADER_TRANSPOSE_EN to store memory row i into buffer column i (needs ROWS == COLS).
module matmul_input_loader
  import matmul_io_pkg::*;
#(
  parameter int unsigned ROWS               = 4,
  parameter int unsigned COLS               = 4,
  parameter int unsigned WORD_SIZE          = 16,
  parameter int unsigned MEM_ACCESS_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stall,
  output logic [31:0]               mem_addr,
  output logic                      mem_rd_en,
  input  logic [MemPortWidth-1:0]   mem_rd_data,
  output logic [COLS*WORD_SIZE-1:0] matmul_input,
  output logic [COLS-1:0]           matmul_input_valid,
  output logic                      load_rdy,
  output logic                      load_done
);

  localparam int unsigned NumBeats = stream_beats(ROWS, COLS);
  localparam int unsigned BeatW    = $clog2(NumBeats + 1);
  localparam int unsigned RowW     = $clog2(ROWS + 1);
  localparam int unsigned DelayW   = $clog2(MEM_ACCESS_LATENCY + 1);
  localparam int unsigned BufW     = ROWS * COLS * WORD_SIZE;
  localparam int unsigned LaneW    = COLS * WORD_SIZE;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(NumBeats - 1);

  if (MemPortWidth < LaneW) begin : g_port_chk
    $error("mem_rd_data narrower than COLS*WORD_SIZE");
  end
  if (MEM_ACCESS_LATENCY < 1) begin : g_lat_chk
    $error("MEM_ACCESS_LATENCY must be at least 1");
  end
`ifdef LOADER_TRANSPOSE_EN
  if (ROWS != COLS) begin : g_tr_chk
    $error("LOADER_TRANSPOSE_EN requires ROWS == COLS");
  end
`endif

  if (MemPortWidth > LaneW) begin : g_unused_hi
    logic unused_rd_hi;
    assign unused_rd_hi = ^mem_rd_data[MemPortWidth-1:LaneW];
  end

  loader_state_e     state_q, state_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [DelayW-1:0] delay_q, delay_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic              phase_q, phase_d;
  logic [31:0]       addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic [BufW-1:0]   buf_q, buf_d;
  logic [LaneW-1:0]  data_q, data_d;
  logic [COLS-1:0]   valid_q, valid_d;

  logic [BeatW-1:0]  skew_beat;
  logic [LaneW-1:0]  skew_data;
  logic [COLS-1:0]   skew_valid;
  logic              load_stream;

  // Beat that becomes visible after the next edge when the output registers reload.
  assign skew_beat = (state_q == StStream) ? beat_q + 1'b1 : '0;

  matmul_input_skew #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .WORD_SIZE (WORD_SIZE),
    .BEAT_W    (BeatW)
  ) u_skew (
    .buf_flat   (buf_q),
    .beat       (skew_beat),
    .lane_data  (skew_data),
    .lane_valid (skew_valid)
  );

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    delay_d     = delay_q;
    beat_d      = beat_q;
    phase_d     = phase_q;
    addr_d      = addr_q;
    rd_en_d     = 1'b0;
    buf_d       = buf_q;
    data_d      = data_q;
    valid_d     = valid_q;
    load_stream = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StMemRd;
          row_d   = '0;
        end
      end
      StMemRd: begin
        if (row_q < RowW'(ROWS)) begin
          addr_d  = InputMatBaseAddr + 32'(row_q) * MemAddrIncr;
          rd_en_d = 1'b1;
          delay_d = DelayW'(MEM_ACCESS_LATENCY - 1);
          state_d = StMemRdDelay;
        end else begin
          state_d     = StStream;
          beat_d      = '0;
          phase_d     = 1'b0;
          load_stream = 1'b1;
        end
      end
      StMemRdDelay: begin
        if (delay_q == '0) begin
          for (int j = 0; j < int'(COLS); j++) begin
`ifdef LOADER_TRANSPOSE_EN
            buf_d[(j * int'(COLS) + int'(row_q)) * int'(WORD_SIZE) +: WORD_SIZE] =
                mem_rd_data[j * int'(WORD_SIZE) +: WORD_SIZE];
`else
            buf_d[(int'(row_q) * int'(COLS) + j) * int'(WORD_SIZE) +: WORD_SIZE] =
                mem_rd_data[j * int'(WORD_SIZE) +: WORD_SIZE];
`endif
          end
          row_d   = row_q + 1'b1;
          state_d = StMemRd;
        end else begin
          delay_d = delay_q - 1'b1;
        end
      end
      StStream: begin
        if (!stall) begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else if (beat_q == LastBeat) begin
            state_d = StDone;
            data_d  = '0;
            valid_d = '0;
          end else begin
            beat_d      = beat_q + 1'b1;
            phase_d     = 1'b0;
            load_stream = 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (load_stream) begin
      data_d  = skew_data;
      valid_d = skew_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      delay_q <= '0;
      beat_q  <= '0;
      phase_q <= 1'b0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      buf_q   <= '0;
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      delay_q <= delay_d;
      beat_q  <= beat_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign mem_addr           = addr_q;
  assign mem_rd_en          = rd_en_q;
  assign matmul_input       = data_q;
  assign matmul_input_valid = valid_q;
  assign load_rdy           = (state_q == StIdle);
  assign load_done          = (state_q == StDone);

endmodule

// File: tb/tb_matmul_input_loader.sv
// Directed/random bench for matmul_input_loader against a matrix-level reference model.
module tb_matmul_input_loader;
  import matmul_io_pkg::*;

  localparam int R   = 4;
  localparam int C   = 4;
  localparam int W   = 16;
  localparam int LAT = 2;
  localparam int NB  = R + C - 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    start = 1'b0;
  logic                    stall = 1'b0;
  logic [31:0]             mem_addr;
  logic                    mem_rd_en;
  logic [MemPortWidth-1:0] mem_rd_data = '0;
  logic [C*W-1:0]          matmul_input;
  logic [C-1:0]            matmul_input_valid;
  logic                    load_rdy;
  logic                    load_done;

  int vectors = 0;
  int errors  = 0;

  logic [W-1:0] mat [R][C];

  always #5 clk = ~clk;

  matmul_input_loader #(
    .ROWS               (R),
    .COLS               (C),
    .WORD_SIZE          (W),
    .MEM_ACCESS_LATENCY (LAT)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .stall              (stall),
    .mem_addr           (mem_addr),
    .mem_rd_en          (mem_rd_en),
    .mem_rd_data        (mem_rd_data),
    .matmul_input       (matmul_input),
    .matmul_input_valid (matmul_input_valid),
    .load_rdy           (load_rdy),
    .load_done          (load_done)
  );

  // Memory row word; bits above the lanes are all-ones so ignoring them is observable.
  function automatic logic [MemPortWidth-1:0] row_word(input logic [31:0] addr);
    logic [MemPortWidth-1:0] w = '1;
    int idx = int'((addr - InputMatBaseAddr) / MemAddrIncr);
    if (idx >= 0 && idx < R) begin
      for (int j = 0; j < C; j++) w[j*W +: W] = mat[idx][j];
    end
    return w;
  endfunction

  // With latency 2 the data sits on the port from the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= row_word(mem_addr);
  end

  function automatic logic [W-1:0] buf_elem(input int r, input int c);
`ifdef LOADER_TRANSPOSE_EN
    return mat[c][r];
`else
    return mat[r][c];
`endif
  endfunction

  function automatic logic [C*W-1:0] exp_data(input int t);
    logic [C*W-1:0] d = '0;
    for (int c = 0; c < C; c++) if (t - c >= 0 && t - c < R) d[c*W +: W] = buf_elem(t - c, c);
    return d;
  endfunction

  function automatic logic [C-1:0] exp_valid(input int t);
    logic [C-1:0] v = '0;
    for (int c = 0; c < C; c++) if (t - c >= 0 && t - c < R) v[c] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) mat[i][j] = W'(16 * i + j);
  endtask

  task automatic fill_random();
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) mat[i][j] = W'($urandom);
  endtask

  // One full load from start; optional stall window, abort point and input noise.
  task automatic run_load(input int stall_at, input int stall_len, input int abort_at,
                          input bit noise);
    int cyc = 0, last_rd = 0, n_rd = 0, p = 0, k = 0, stall_left = 0;
    bit streaming = 0, done = 0, stalled = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rdy_low_after_start", load_rdy, 0);
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (noise) start = 1'($urandom_range(0, 1));
      if (!streaming) begin
        if (noise) stall = 1'($urandom_range(0, 1));
        chk("rdy_low_during_read", load_rdy, 0);
        if (mem_rd_en) begin
          chk("rd_addr", mem_addr, InputMatBaseAddr + 32'(n_rd) * MemAddrIncr);
          if (n_rd > 0) chk("rd_period", cyc - last_rd, LAT + 1);
          last_rd = cyc;
          n_rd++;
        end
        if (matmul_input_valid != '0) begin
          streaming = 1;
          chk("rd_count", n_rd, R);
          chk("stream_start_delay", cyc - last_rd, LAT + 1);
        end
      end
      if (streaming) begin
        if (p == 2 * NB) begin
          chk("end_valid", matmul_input_valid, 0);
          chk("end_data", matmul_input, 0);
          chk("load_done_pulse", load_done, 1);
          done = 1;
        end else begin
          chk("lane_data", matmul_input, exp_data(p / 2));
          chk("lane_valid", matmul_input_valid, exp_valid(p / 2));
          chk("done_low_in_stream", load_done, 0);
          chk("no_rd_in_stream", mem_rd_en, 0);
          k++;
          if (p == abort_at) begin
            start = 1'b0;
            stall = 1'b0;
            rst   = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            chk("abort_valid", matmul_input_valid, 0);
            chk("abort_data", matmul_input, 0);
            chk("abort_rdy", load_rdy, 1);
            chk("abort_rd_en", mem_rd_en, 0);
            for (int i = 0; i < 30; i++) begin
              @(negedge clk);
              chk("abort_no_done", load_done, 0);
              chk("abort_no_valid", matmul_input_valid, 0);
            end
            return;
          end
          if (!stalled && p == stall_at) begin
            stalled    = 1;
            stall_left = stall_len;
          end
          if (stall_left > 0) begin
            stall = 1'b1;
            stall_left--;
          end else begin
            stall = 1'b0;
            p++;
          end
        end
      end
    end
    start = 1'b0;
    stall = 1'b0;
    chk("load_finished", done, 1);
    chk("stream_cycles", k, 2 * NB + (stall_at >= 0 ? stall_len : 0));
    @(negedge clk);
    chk("rdy_after_done", load_rdy, 1);
    chk("done_one_cycle", load_done, 0);
    @(negedge clk);
    chk("idle_holds", load_rdy, 1);
    chk("idle_no_rd", mem_rd_en, 0);
  endtask

  initial begin
    int sa, sl;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", load_rdy, 1);
    chk("rst_done", load_done, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", matmul_input_valid, 0);
    chk("rst_data", matmul_input, 0);
    rst = 1'b1;
    @(negedge clk);

    fill_pattern();
    run_load(-1, 0, -1, 1'b0);

    fill_pattern();
    run_load(4, 5, -1, 1'b0);

    fill_random();
    sa = int'($urandom_range(0, 2 * NB - 1));
    sl = int'($urandom_range(1, 6));
    run_load(sa, sl, -1, 1'b1);

    fill_random();
    run_load(-1, 0, 8, 1'b0);
    fill_random();
    run_load(-1, 0, -1, 1'b0);

    for (int n = 0; n < 3; n++) begin
      fill_random();
      sa = int'($urandom_range(0, 2 * NB - 1));
      sl = int'($urandom_range(1, 4));
      run_load(sa, sl, -1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/matmul_input_loader.md
Name: matmul_input_loader

Overview:
- Reads an operand matrix from memory row by row, buffers it, then streams it into the systolic array as skewed, double-held lanes.
- Mirror of the output write-back path, on the input side. It feeds the per-column operand lanes of systolic_matmul_fsm.
- Lane timing matches the array's double-buffered MACs: every beat is held for 2 clk cycles.

Parameters:
- ROWS, 4, rows of buffered matrix (memory rows read).
- COLS, 4, columns of buffered matrix; number of output lanes.
- WORD_SIZE, 16, bits per element.
- MEM_ACCESS_LATENCY, 2, cycles from mem_rd_en to valid mem_rd_data (>=1).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- start  in  1  begin load; sampled only in IDLE.
- stall  in  1  freezes streaming.
- mem_addr  out  32  read address.
- mem_rd_en  out  1  one-cycle read strobe per row.
- mem_rd_data  in  `MEM_PORT_WIDTH  read data; element c at [c*WORD_SIZE +: WORD_SIZE]; bits above COLS*WORD_SIZE ignored.
- matmul_input  out  COLS*WORD_SIZE  lane data; lane c at [c*WORD_SIZE +: WORD_SIZE].
- matmul_input_valid  out  COLS  per-lane valid.
- load_rdy  out  1  high in IDLE.
- load_done  out  1  one-cycle pulse at end of stream.

Behaviour:
- Reset (rst=0 at edge) values:
  - state IDLE, load_rdy=1, load_done=0, mem_rd_en=0, mem_addr=0.
  - matmul_input=0, matmul_input_valid=0.
  - buffer, row and beat counters cleared.
  - Reset mid-operation aborts immediately; no further reads or valids.
- States: IDLE, MEM_RD, MEM_RD_DELAY, STREAM, DONE.
- IDLE:
  - load_rdy=1.
  - start=1 moves to MEM_RD and sets load_rdy=0 next cycle.
  - start outside IDLE is ignored.
- MEM_RD:
  - if row_idx<ROWS: mem_addr <= `INPUT_MAT_BASE_ADDR + row_idx*`MEM_ADDR_INCR; mem_rd_en <= 1; delay <= MEM_ACCESS_LATENCY-1; go to MEM_RD_DELAY.
  - else: go to STREAM with beat=0, phase=0.
- MEM_RD_DELAY:
  - mem_rd_en <= 0; decrement delay.
  - when delay==0: capture mem_rd_data into buffer row row_idx, row_idx++, return to MEM_RD.
  - Row issue period is MEM_ACCESS_LATENCY+1 cycles.
- STREAM:
  - beat t runs 0..ROWS+COLS-2.
  - Lane c: valid[c]=1 and data=buf[t-c][c] when 0<=t-c<ROWS; otherwise valid[c]=0 and data=0.
  - Each beat is presented for exactly 2 non-stalled cycles (phase toggles); outputs are registered.
  - stall=1 holds beat, phase, data and valid unchanged.
  - After the final beat's second cycle: valid=0, go to DONE.
- DONE: load_done=1 for one cycle, then IDLE.
- stall has no effect outside STREAM; reads are never stalled.
- Buffer contents persist after DONE until the next load or reset.

Optional Feature:
- Macro: LOADER_TRANSPOSE_EN.
- Defined: memory row i is written into buffer column i (buf[j][i] = row_i[j]). Requires ROWS==COLS; enforce with an elaboration-time error otherwise.
- Undefined: memory row i is written into buffer row i.
- Streaming order is identical in both cases.

Decomposition:
- Package matmul_io_pkg:
  - loader state enum.
  - localparam wrappers for `INPUT_MAT_BASE_ADDR, `MEM_ADDR_INCR, `MEM_PORT_WIDTH.
  - stream_beats(ROWS,COLS) function returning ROWS+COLS-1.
- Sub-module matmul_input_skew: combinational lane selection from buffer plus beat index, producing lane data and valid vectors. The parent registers its outputs.

Test Plan (4x4, WORD_SIZE 16, latency 2, memory row i element j = 16*i+j):
- Reset: hold rst=0 for 3 cycles -> load_rdy=1, load_done=0, mem_rd_en=0, matmul_input_valid=4'b0000, matmul_input=0.
- Reads: pulse start -> exactly 4 mem_rd_en pulses, 3 cycles apart, at base, base+INCR, base+2*INCR, base+3*INCR; load_rdy=0 throughout.
- Stream:
  - beat0: lane0=0x00, valid=0001.
  - beat1: lane0=0x10, lane1=0x01, valid=0011.
  - beat3: valid=1111, lanes 0x30/0x21/0x12/0x03.
  - beat6: lane3=0x33, valid=1000.
  - Each beat held 2 cycles (14 cycles total), then load_done pulse for 1 cycle.
- Stall: assert stall for 5 cycles during beat 2 -> outputs frozen at beat-2 values; stream lasts 19 cycles; data sequence unchanged.
- Reset mid-stream: rst=0 at beat 4 -> next cycle valid=0000, load_rdy=1, load_done never pulses; a following start completes a correct full load.
- LOADER_TRANSPOSE_EN defined -> beat1: lane0=0x01, lane1=0x10; beat6: lane3=0x33.
